ip_codma_bus_arbiter: RTL and testbench

// - N-master to 1-slave arbiter on the CODMA bus protocol (read/write/addr/size, grant, data phase, error).
// - Round-robin ownership, held from address phase through the last data beat.
// - Adds burst beat tracking, local rejection of illegal requests, and a slave-response timeout.
// - Sits between the CODMA channel engines and the shared memory-side bus slave.

---
 rtl/ip_codma_pkg.sv | 31 +++
 rtl/ip_codma_rr_picker.sv | 44 ++++
 rtl/ip_codma_bus_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_ip_codma_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_codma_pkg.sv
// ---------------------------------------------------------------------------
// ip_codma_pkg
// Shared definitions for the CODMA bus arbiter:
//   - legal transfer size codes (one beat = one double-word)
//   - arbiter state enum arb_state_e
//   - size_to_beats(): size code -> beat count (0 for an illegal code)
// ---------------------------------------------------------------------------
package ip_codma_pkg;

    localparam logic [3:0] SZ_1DW = 4'h1;
    localparam logic [3:0] SZ_2DW = 4'h2;
    localparam logic [3:0] SZ_4DW = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_REJ  = 2'd3
    } arb_state_e;

    // A return of 0 marks the size code as illegal.
    function automatic logic [2:0] size_to_beats(input logic [3:0] size);
        case (size)
            SZ_1DW:  size_to_beats = 3'd1;
            SZ_2DW:  size_to_beats = 3'd2;
            SZ_4DW:  size_to_beats = 3'd4;
            default: size_to_beats = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ip_codma_rr_picker.sv
// ---------------------------------------------------------------------------
// ip_codma_rr_picker
// Purely combinational round-robin picker: returns the first asserted
// request at or above rr_ptr, wrapping modulo NUM_MASTERS.
// Ports:
//   req     in   NUM_MASTERS  request vector
//   rr_ptr  in   IDX_W        index with highest priority this cycle
//   valid   out  1            at least one request present
//   index   out  IDX_W        winning master index (0 when !valid)
// ---------------------------------------------------------------------------
module ip_codma_rr_picker #(
    parameter  int NUM_MASTERS = 4,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic                   valid,
    output logic [IDX_W-1:0]       index
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest offset down to offset 0 so the nearest
    // requester (smallest offset from rr_ptr) is the last, winning write.
    always_comb begin
        valid    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
            cand = int'(rr_ptr) + off;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ip_codma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ip_codma_bus_arbiter
// N-master to 1-slave arbiter for the CODMA bus. Ownership is round-robin
// and is held from the address phase through the last data beat. Illegal
// requests are rejected locally; a stalled slave is aborted after
// TIMEOUT_CYCLES cycles.
//
// Handshake: a master holds m_read/m_write, m_addr and m_size stable until it
// sees m_grant (address phase end). A data beat transfers in any DATA cycle
// where the producing side's valid is high (s_read_valid for reads,
// m_write_valid[owner] for writes); there is no back-pressure on beats.
// m_error is a one-cycle pulse to the owner and always ends the transaction.
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   m_read/m_write/m_addr/m_size      per-master address-phase request
//   m_write_data/m_write_valid        per-master write beats
//   m_grant/m_read_valid/m_error      per-master responses, owner only
//   m_read_data                       read data to masters
//   s_read/s_write/s_addr/s_size      slave-side address phase
//   s_grant/s_error                   slave address/transaction response
//   s_read_data/s_read_valid          slave read beats
//   s_write_data/s_write_valid        owner write beats to slave
//   busy                              state != IDLE
//   owner                             current / last owner index
//   dbg_state                         FSM state for debug and checkers
// ---------------------------------------------------------------------------
module ip_codma_bus_arbiter
    import ip_codma_pkg::*;
#(
    parameter  int NUM_MASTERS    = 4,
    parameter  int ADDR_W         = 32,
    parameter  int DATA_W         = 64,
    parameter  int SIZE_W         = 4,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = $clog2(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*SIZE_W-1:0] m_size,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_write_data,
    input  logic [NUM_MASTERS-1:0]        m_write_valid,
    output logic [NUM_MASTERS-1:0]        m_grant,
    output logic [DATA_W-1:0]             m_read_data,
    output logic [NUM_MASTERS-1:0]        m_read_valid,
    output logic [NUM_MASTERS-1:0]        m_error,
    output logic                          s_read,
    output logic                          s_write,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [SIZE_W-1:0]             s_size,
    input  logic                          s_grant,
    input  logic [DATA_W-1:0]             s_read_data,
    input  logic                          s_read_valid,
    output logic [DATA_W-1:0]             s_write_data,
    output logic                          s_write_valid,
    input  logic                          s_error,
    output logic                          busy,
    output logic [IDX_W-1:0]              owner,
    output arb_state_e                    dbg_state
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    arb_state_e       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [2:0]       beat_cnt;
    logic [TMR_W-1:0] timer;
    logic             dir_write;

    // Legal only if the code fits in the 4-bit size space and maps to beats.
    function automatic logic size_ok(input logic [SIZE_W-1:0] s);
        size_ok = ((s >> 4) == '0) && (size_to_beats(4'(s)) != 3'd0);
    endfunction

    // ---- round-robin pick among current requesters ----
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    ip_codma_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .req    (m_read | m_write),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    // Legality is judged on the winner's inputs before it becomes owner.
    logic win_illegal;
    assign win_illegal = (m_read[pick_idx] & m_write[pick_idx])
                       | ~size_ok(m_size[pick_idx*SIZE_W +: SIZE_W]);

    // ---- owner's live inputs ----
    logic              own_read, own_write, own_req;
    logic [ADDR_W-1:0] own_addr;
    logic [SIZE_W-1:0] own_size;
    logic [DATA_W-1:0] own_wdata;

    assign own_read  = m_read[owner];
    assign own_write = m_write[owner];
    assign own_req   = own_read | own_write;
    assign own_addr  = m_addr[owner*ADDR_W +: ADDR_W];
    assign own_size  = m_size[owner*SIZE_W +: SIZE_W];
    assign own_wdata = m_write_data[owner*DATA_W +: DATA_W];

    logic             timeout_hit;
    logic             beat;
    logic [IDX_W-1:0] owner_next;

    assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign beat        = (state == ST_DATA)
                       & (dir_write ? m_write_valid[owner] : s_read_valid);
    assign owner_next  = (owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;

    // ---- FSM and counters ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            timer     <= '0;
            dir_write <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        timer <= '0;
                        state <= win_illegal ? ST_REJ : ST_ADDR;
                    end
                end
                ST_REJ: begin
                    state  <= ST_IDLE;
                    rr_ptr <= owner_next;
                end
                ST_ADDR: begin
                    timer <= timer + 1'b1;
                    if (s_grant) begin
                        if (s_error) begin
                            state  <= ST_IDLE;
                            rr_ptr <= owner_next;
                        end else begin
                            state     <= ST_DATA;
                            beat_cnt  <= size_to_beats(4'(own_size));
                            dir_write <= own_write;
                            timer     <= '0;
                        end
                    end else if (!own_req || timeout_hit) begin
                        state  <= ST_IDLE;
                        rr_ptr <= owner_next;
                    end
                end
                ST_DATA: begin
                    timer <= timer + 1'b1;
                    if (s_error || (!beat && timeout_hit)) begin
                        state  <= ST_IDLE;
                        rr_ptr <= owner_next;
                    end else if (beat) begin
                        timer    <= '0;
                        beat_cnt <= beat_cnt - 3'd1;
                        if (beat_cnt == 3'd1) begin
                            state  <= ST_IDLE;
                            rr_ptr <= owner_next;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---- output decode; everything is zero in IDLE ----
    always_comb begin
        m_grant       = '0;
        m_error       = '0;
        m_read_valid  = '0;
        m_read_data   = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_addr        = '0;
        s_size        = '0;
        s_write_data  = '0;
        s_write_valid = 1'b0;
        case (state)
            ST_REJ: begin
                m_grant[owner] = 1'b1;
                m_error[owner] = 1'b1;
            end
            ST_ADDR: begin
                s_read         = own_read;
                s_write        = own_write;
                s_addr         = own_addr;
                s_size         = own_size;
                m_grant[owner] = s_grant;
                if (s_grant) begin
                    m_error[owner] = s_error;
                end else if (own_req && timeout_hit) begin
                    // Abort also ends the master's address phase.
                    m_grant[owner] = 1'b1;
                    m_error[owner] = 1'b1;
                end
            end
            ST_DATA: begin
                if (dir_write) begin
                    s_write_valid = m_write_valid[owner];
                    s_write_data  = own_wdata;
                end else begin
                    m_read_valid[owner] = s_read_valid;
                    m_read_data         = s_read_data;
                end
                m_error[owner] = s_error | (!beat & timeout_hit);
            end
            default: ;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ip_codma_bus_arbiter
// Directed bench for ip_codma_bus_arbiter (4 masters, TIMEOUT_CYCLES=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_ip_codma_bus_arbiter;
    import ip_codma_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = 4;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    m_read, m_write, m_write_valid;
    logic [N*AW-1:0] m_addr;
    logic [N*SW-1:0] m_size;
    logic [N*DW-1:0] m_write_data;
    logic [N-1:0]    m_grant, m_read_valid, m_error;
    logic [DW-1:0]   m_read_data;
    logic            s_read, s_write, s_grant, s_read_valid, s_write_valid, s_error;
    logic [AW-1:0]   s_addr;
    logic [SW-1:0]   s_size;
    logic [DW-1:0]   s_read_data, s_write_data;
    logic            busy;
    logic [1:0]      owner;
    arb_state_e      dbg_state;

    ip_codma_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_size(m_size),
        .m_write_data(m_write_data), .m_write_valid(m_write_valid),
        .m_grant(m_grant), .m_read_data(m_read_data), .m_read_valid(m_read_valid),
        .m_error(m_error), .s_read(s_read), .s_write(s_write), .s_addr(s_addr),
        .s_size(s_size), .s_grant(s_grant), .s_read_data(s_read_data),
        .s_read_valid(s_read_valid), .s_write_data(s_write_data),
        .s_write_valid(s_write_valid), .s_error(s_error), .busy(busy),
        .owner(owner), .dbg_state(dbg_state)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- scoreboard ----
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---- drivers ----
    task automatic set_m(input int i, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [3:0] sz);
        m_read[i]            = rd;
        m_write[i]           = wr;
        m_addr[i*AW +: AW]   = a;
        m_size[i*SW +: SW]   = sz;
    endtask

    // One single-beat read, entered with the DUT in ADDR for exp_own.
    task automatic read_one(input logic [63:0] exp_own, input logic [63:0] d);
        @(negedge clk); #1;
        check("rr_owner", owner, exp_own);
        check("rr_s_read", s_read, 1);
        check("rr_s_addr", s_addr, 64'h100 * (exp_own + 1));
        s_grant = 1'b1; #1;
        check("rr_grant", m_grant, 64'd1 << exp_own);
        @(negedge clk);
        s_grant = 1'b0; s_read_valid = 1'b1; s_read_data = d; #1;
        check("rr_rvalid", m_read_valid, 64'd1 << exp_own);
        check("rr_rdata", m_read_data, d);
        @(negedge clk);
        s_read_valid = 1'b0; s_read_data = '0; #1;
        check("rr_idle", busy, 0);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    // ---- watchdog ----
    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        summary();
        $fatal(1, "watchdog");
    end

    // ---- stimulus ----
    logic [5:0] vpat;
    int         beats_left;
    int         n_fwd;
    logic       exp_sv;
    logic       exp_busy;

    initial begin
        reset_n = 1'b0;
        m_read = '0; m_write = '0; m_write_valid = '0;
        m_addr = '0; m_size = '0; m_write_data = '0;
        s_grant = 1'b0; s_read_valid = 1'b0; s_error = 1'b0;
        s_read_data = 64'hDEAD_BEEF_0000_0001;
        for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b0, 32'h100 * (i + 1), SZ_1DW);

        // 1. reset with all masters requesting
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant", m_grant, 0);
        check("rst_error", m_error, 0);
        check("rst_rvalid", m_read_valid, 0);
        check("rst_rdata", m_read_data, 0);
        check("rst_s_read", s_read, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_s_wvalid", s_write_valid, 0);
        check("rst_owner", owner, 0);
        reset_n = 1'b1;
        s_read_data = '0;

        // 2. round robin 0,1,2,3,0
        exp_q = {64'd0, 64'd1, 64'd2, 64'd3, 64'd0};
        for (int k = 0; k < 5; k++) read_one(exp_q.pop_front(), 64'h1111_0000 + 64'(k));
        m_read = '0;

        // 3. M2 4-beat write; M1 write_valid noise throughout
        set_m(2, 1'b0, 1'b1, 32'h1000, SZ_4DW);
        m_write_valid[1] = 1'b1;
        m_write_data[1*DW +: DW] = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk); #1;
        check("burst_owner", owner, 2);
        check("burst_s_write", s_write, 1);
        check("burst_s_addr", s_addr, 32'h1000);
        check("burst_s_size", s_size, SZ_4DW);
        s_grant = 1'b1; #1;
        check("burst_grant", m_grant, 4'b0100);
        vpat = 6'b111011;
        beats_left = 4;
        n_fwd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            s_grant = 1'b0;
            m_write[2] = 1'b0;
            m_write_valid[2] = vpat[c];
            m_write_data[2*DW +: DW] = 64'hC0DE_0000_0000_0000 + 64'(c);
            exp_busy = (beats_left > 0);
            exp_sv = (beats_left > 0) && vpat[c];
            if (exp_sv) begin
                exp_q.push_back(64'hC0DE_0000_0000_0000 + 64'(c));
                beats_left--;
            end
            #1;
            check("burst_busy", busy, exp_busy);
            check("burst_s_wvalid", s_write_valid, exp_sv);
            check("burst_s_write_data_phase", s_write, 0);
            if (s_write_valid && exp_q.size() > 0) begin
                n_fwd++;
                check("burst_wdata", s_write_data, exp_q.pop_front());
            end
        end
        check("burst_beats", n_fwd, 4);
        m_write_valid = '0;

        // 4. illegal size on M1, then read+write together on M3
        set_m(1, 1'b1, 1'b0, 32'h2000, 4'h3);
        @(negedge clk); #1;
        check("rej_size_grant", m_grant, 4'b0010);
        check("rej_size_error", m_error, 4'b0010);
        check("rej_size_s_read", s_read, 0);
        check("rej_size_s_write", s_write, 0);
        m_read[1] = 1'b0;
        @(negedge clk); #1;
        check("rej_size_done", busy, 0);
        check("rej_size_err_clr", m_error, 0);
        set_m(3, 1'b1, 1'b1, 32'h3000, SZ_2DW);
        @(negedge clk); #1;
        check("rej_rw_grant", m_grant, 4'b1000);
        check("rej_rw_error", m_error, 4'b1000);
        check("rej_rw_s_read", s_read, 0);
        check("rej_rw_s_write", s_write, 0);
        m_read[3] = 1'b0; m_write[3] = 1'b0;
        @(negedge clk); #1;
        check("rej_rw_done", busy, 0);

        // 5. slave error on beat 2 of a 4-beat read, then M1 served
        set_m(0, 1'b1, 1'b0, 32'h4000, SZ_4DW);
        set_m(1, 1'b1, 1'b0, 32'h5000, SZ_1DW);
        @(negedge clk); #1;
        check("serr_owner", owner, 0);
        check("serr_s_size", s_size, SZ_4DW);
        s_grant = 1'b1;
        @(negedge clk);
        s_grant = 1'b0; m_read[0] = 1'b0;
        s_read_valid = 1'b1; s_read_data = 64'h5A5A_0001; #1;
        check("serr_beat1_valid", m_read_valid, 4'b0001);
        check("serr_beat1_noerr", m_error, 0);
        @(negedge clk);
        s_error = 1'b1; s_read_data = 64'h5A5A_0002; #1;
        check("serr_error", m_error, 4'b0001);
        check("serr_beat2_valid", m_read_valid, 4'b0001);
        check("serr_beat2_data", m_read_data, 64'h5A5A_0002);
        @(negedge clk);
        s_read_valid = 1'b0; s_error = 1'b0; #1;
        check("serr_idle", busy, 0);
        @(negedge clk); #1;
        check("serr_next_owner", owner, 1);
        check("serr_next_s_read", s_read, 1);
        check("serr_next_s_addr", s_addr, 32'h5000);
        m_read[1] = 1'b0; #1;
        check("drop_s_read", s_read, 0);
        check("drop_grant", m_grant, 0);
        check("drop_error", m_error, 0);
        @(negedge clk); #1;
        check("drop_idle", busy, 0);

        // 6. slave never grants M2 -> abort on ADDR cycle 8
        set_m(2, 1'b1, 1'b0, 32'h6000, SZ_1DW);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            check("tmo_busy", busy, 1);
            if (k < 8) begin
                check("tmo_wait_err", m_error, 0);
            end else begin
                check("tmo_error", m_error, 4'b0100);
                check("tmo_grant", m_grant, 4'b0100);
            end
        end
        m_read[2] = 1'b0;
        @(negedge clk); #1;
        check("tmo_idle", busy, 0);

        // reset in the middle of a write burst
        set_m(3, 1'b0, 1'b1, 32'h7000, SZ_4DW);
        @(negedge clk); #1;
        check("mrst_owner", owner, 3);
        s_grant = 1'b1;
        @(negedge clk);
        s_grant = 1'b0; m_write[3] = 1'b0;
        m_write_valid[3] = 1'b1; m_write_data[3*DW +: DW] = 64'h77; #1;
        check("mrst_wvalid_before", s_write_valid, 1);
        reset_n = 1'b0;
        @(negedge clk); #1;
        check("mrst_wvalid_after", s_write_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_owner_clr", owner, 0);
        check("mrst_error", m_error, 0);
        reset_n = 1'b1;
        m_write_valid = '0;
        set_m(1, 1'b1, 1'b0, 32'h8000, SZ_1DW);
        set_m(3, 1'b1, 1'b0, 32'h9000, SZ_1DW);
        @(negedge clk); #1;
        check("post_rst_owner", owner, 1);
        check("post_rst_error", m_error, 0);
        m_read = '0;
        @(negedge clk); #1;
        check("post_rst_idle", busy, 0);

        summary();
        $finish;
    end

endmodule
